sub_16_bit_serial: RTL and testbench
====================================

# sub_16_bit_serial

Sequential 16-bit subtractor with borrow chain: the inverse datapath partner of the team's 16-bit ripple adder, used where area matters more than latency. Accepts one operand pair per transaction over a valid/ready handshake, subtracts DIGIT_W bits per clock (LSB first), and presents the difference, borrow-out and signed-overflow flag on a held output handshake.

## Interface
- WIDTH, 16: operand width; must be a multiple of DIGIT_W.
- DIGIT_W, 1: bits processed per clock; legal values 1, 2, 4, 8, 16.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- borrowIn  in  1  borrow into bit 0.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- diff  out  WIDTH  a − b − borrowIn, modulo 2^WIDTH.
- borrowOut  out  1  1 iff unsigned a < b + borrowIn.
- overflow  out  1  two's-complement overflow: a[MSB]≠b[MSB] and diff[MSB]≠a[MSB].

One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at an edge: latch a, b into shift registers, borrowIn into borrow register, clear digit counter, go RUN. Operand inputs ignored otherwise.
- RUN: each edge subtracts the low DIGIT_W bits of the a/b shift registers with current borrow; result digit shifts into diff register from the top; a/b shift right by DIGIT_W; borrow register updates; counter increments. After WIDTH/DIGIT_W digits go DONE.
- DONE: out_valid=1; diff, borrowOut, overflow stable. On out_valid&out_ready go IDLE. No acceptance of new operands in the same cycle (in_ready low in DONE).
- overflow computed from latched MSBs of a, b and final diff MSB; registered on DONE entry.
- borrowOut = final borrow register.
- Reset (any state, any time, asynchronous): state→IDLE, counter, shift registers, diff, borrowOut, overflow, out_valid→0; in_ready→1 after reset release. In-flight transaction discarded, no partial result emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, diff=0, borrowOut=0, overflow=0.
- Latency: accept edge E0; RUN at edges E1..EN, N=WIDTH/DIGIT_W; out_valid high from EN until the accepting edge. WIDTH=16: DIGIT_W=1 → 16 cycles, DIGIT_W=4 → 4 cycles.
- Throughput: one result per N+2 cycles with out_ready tied high.
- out_ready low: outputs held indefinitely, no change to diff/flags.
- in_valid during RUN/DONE: ignored, not queued; upstream must hold it.
- out_ready high while out_valid low: no effect.
- diff/flags change only on DONE entry or reset; intermediate digits not observable on diff.

## Structure
- Package sub_serial_pkg: FSM state enum (IDLE/RUN/DONE), default WIDTH and DIGIT_W constants.
- Sub-module sub_digit: combinational DIGIT_W-bit ripple subtractor (a, b, borrow in → difference digit, borrow out), built from full-subtractor cells; instantiated once in the top.
- Top holds FSM, counter ($clog2(N+1) bits), shift registers, result/flag registers.

## Test plan
- a=0x0001, b=0x0001, borrowIn=0 → diff=0x0000, borrowOut=0, overflow=0, out_valid exactly 16 cycles after accept (DIGIT_W=1).
- a=0xF0F0, b=0x0001, borrowIn=0 → diff=0xF0EF, borrowOut=0, overflow=0; a=0x0005, b=0x0001, borrowIn=1 → diff=0x0003.
- a=0x0000, b=0x0001, borrowIn=0 → diff=0xFFFF, borrowOut=1, overflow=0; a=0x8000, b=0x0001 → diff=0x7FFF, borrowOut=0, overflow=1.
- Backpressure: out_ready low 5 cycles after out_valid → outputs and out_valid stable, in_ready=0; in_valid pulsed during RUN not accepted.
- rst_n asserted at RUN cycle 7 → all outputs reset immediately; next transaction a=0x1234, b=0x0234 → diff=0x1000, no stale result.
- Random 1000 pairs at DIGIT_W=1 and 4 vs. reference model a−b−borrowIn, checking diff, borrowOut, overflow and latency N.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// rtl/sub_serial_pkg.sv - shared types and defaults for the serial subtractor
//
// Purpose: FSM state encoding and default width/digit constants used by
//          sub_16_bit_serial and its bench.
// Contents: subState (IDLE/RUN/DONE), DEFAULT_WIDTH, DEFAULT_DIGIT_W.

package sub_serial_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_DIGIT_W = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } subState;

endpackage

// File: rtl/sub_digit.sv
// rtl/sub_digit.sv - combinational DIGIT_W-bit ripple subtractor
//
// Purpose: computes aDigit - bDigit - borrowIn for one digit using a chain of
//          full-subtractor cells.
// Ports:
//   aDigit    in  DIGIT_W  minuend digit
//   bDigit    in  DIGIT_W  subtrahend digit
//   borrowIn  in  1        borrow into the lowest bit of the digit
//   diffDigit out DIGIT_W  difference digit
//   borrowOut out 1        borrow out of the highest bit of the digit

module sub_digit #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] aDigit,
    input  logic [DIGIT_W-1:0] bDigit,
    input  logic               borrowIn,
    output logic [DIGIT_W-1:0] diffDigit,
    output logic               borrowOut
);

    logic [DIGIT_W:0] borrowChain;

    assign borrowChain[0] = borrowIn;

    for (genvar i = 0; i < DIGIT_W; i++) begin : gCell
        // Full subtractor: borrow when a < b + borrow at this bit.
        assign diffDigit[i]     = aDigit[i] ^ bDigit[i] ^ borrowChain[i];
        assign borrowChain[i+1] = (~aDigit[i] & bDigit[i])
                                | (~(aDigit[i] ^ bDigit[i]) & borrowChain[i]);
    end

    assign borrowOut = borrowChain[DIGIT_W];

endmodule

// File: rtl/sub_16_bit_serial.sv
// rtl/sub_16_bit_serial.sv - digit-serial subtractor with valid/ready handshakes
//
// Purpose: accepts one operand pair, subtracts DIGIT_W bits per clock LSB first,
//          and holds the difference, borrow-out and signed overflow until taken.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (ready only in IDLE)
//   a, b, borrowIn     minuend, subtrahend, borrow into bit 0
//   out_valid/out_ready result handshake (valid held until accepted)
//   diff               a - b - borrowIn modulo 2^WIDTH
//   borrowOut          unsigned borrow out of the MSB
//   overflow           two's-complement overflow of the subtraction

module sub_16_bit_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    subState            state;
    subState            stateNext;
    logic [CW-1:0]      digitCount;
    logic [WIDTH-1:0]   aShift;
    logic [WIDTH-1:0]   bShift;
    logic [WIDTH-1:0]   diffShift;
    logic [WIDTH-1:0]   diffShiftNext;
    logic               borrowReg;
    logic               aMsb;
    logic               bMsb;
    logic [DIGIT_W-1:0] digitDiff;
    logic               digitBorrow;

    sub_digit #(
        .DIGIT_W(DIGIT_W)
    ) uDigit (
        .aDigit   (aShift[DIGIT_W-1:0]),
        .bDigit   (bShift[DIGIT_W-1:0]),
        .borrowIn (borrowReg),
        .diffDigit(digitDiff),
        .borrowOut(digitBorrow)
    );

    // New digit enters from the top so that after N digits the LSB digit
    // has walked down to bit 0.
    assign diffShiftNext = (diffShift >> DIGIT_W)
                         | (WIDTH'(digitDiff) << (WIDTH - DIGIT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (in_valid) stateNext = RUN;
            RUN:  if (digitCount == LAST_DIGIT) stateNext = DONE;
            DONE: if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digitCount <= '0;
            aShift     <= '0;
            bShift     <= '0;
            diffShift  <= '0;
            borrowReg  <= 1'b0;
            aMsb       <= 1'b0;
            bMsb       <= 1'b0;
            diff       <= '0;
            borrowOut  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aShift     <= a;
                        bShift     <= b;
                        borrowReg  <= borrowIn;
                        digitCount <= '0;
                        aMsb       <= a[WIDTH-1];
                        bMsb       <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    aShift     <= aShift >> DIGIT_W;
                    bShift     <= bShift >> DIGIT_W;
                    diffShift  <= diffShiftNext;
                    borrowReg  <= digitBorrow;
                    digitCount <= digitCount + CW'(1);
                    // Visible results only update as the last digit completes.
                    if (digitCount == LAST_DIGIT) begin
                        diff      <= diffShiftNext;
                        borrowOut <= digitBorrow;
                        overflow  <= (aMsb ^ bMsb) & (diffShiftNext[WIDTH-1] ^ aMsb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_sub_16_bit_serial.sv
// tb/tb_sub_16_bit_serial.sv - self-checking bench for sub_16_bit_serial

module tb_sub_16_bit_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic        in_ready, in_ready4;
    logic [15:0] a = '0, b = '0;
    logic        borrowIn = 1'b0;
    logic        out_valid, out_valid4;
    logic        out_ready = 1'b1, out_ready4 = 1'b1;
    logic [15:0] diff, diff4;
    logic        borrowOut, borrowOut4;
    logic        overflow, overflow4;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    sub_16_bit_serial #(.WIDTH(16), .DIGIT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrowIn(borrowIn), .out_valid(out_valid),
        .out_ready(out_ready), .diff(diff), .borrowOut(borrowOut), .overflow(overflow)
    );

    sub_16_bit_serial #(.WIDTH(16), .DIGIT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .borrowIn(borrowIn), .out_valid(out_valid4),
        .out_ready(out_ready4), .diff(diff4), .borrowOut(borrowOut4), .overflow(overflow4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic refModel(input logic [15:0] ra, input logic [15:0] rb, input logic rbin,
                            output logic [15:0] ed, output logic eb, output logic eo);
        logic [16:0] wide;
        int sa, sb, s;
        wide = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
        ed = wide[15:0];
        eb = wide[16];
        sa = $signed(ra);
        sb = $signed(rb);
        s = sa - sb - int'(rbin);
        eo = (s > 32767) || (s < -32768);
    endtask

    // One transaction on the DIGIT_W=1 instance with out_ready high.
    task automatic runTxn(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                          output int lat, output logic [15:0] d, output logic bo, output logic ov);
        @(negedge clk);
        a = ta; b = tb_; borrowIn = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        d = diff; bo = borrowOut; ov = overflow;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vbin;
        logic [15:0] ed;
        logic        eb;
        logic        eo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, lat4;
        logic [15:0] d, d4, ed, heldDiff;
        logic bo, ov, bo4, ov4, eb, eo, got1, got4;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'hF0F0, 16'h0001, 1'b0, 16'hF0EF, 1'b0, 1'b0};
        vecs[2] = '{16'h0005, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0};
        vecs[3] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        // Reset values
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrowOut), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            runTxn(vecs[i].va, vecs[i].vb, vecs[i].vbin, lat, d, bo, ov);
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_borrow", i), 32'(bo), 32'(vecs[i].eb));
            chk($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].eo));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
        end

        // Backpressure plus in_valid pulse during RUN
        out_ready = 1'b0;
        @(negedge clk);
        a = 16'h1111; b = 16'h0101; borrowIn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin
                chk("bp_in_ready_run", 32'(in_ready), 32'd0);
                a = 16'hFFFF; b = 16'h0000; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        chk("bp_latency", 32'(lat), 32'd16);
        chk("bp_diff", 32'(diff), 32'h1010);
        heldDiff = diff;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_diff", 32'(diff), 32'(heldDiff));
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in RUN cycle 7
        @(negedge clk);
        a = 16'h5555; b = 16'h1111; borrowIn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_borrow", 32'(borrowOut), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        runTxn(16'h1234, 16'h0234, 1'b0, lat, d, bo, ov);
        chk("post_rst_diff", 32'(d), 32'h1000);
        chk("post_rst_borrow", 32'(bo), 32'd0);
        chk("post_rst_latency", 32'(lat), 32'd16);

        // Random pairs on both instances in parallel
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); borrowIn = 1'($urandom);
            in_valid = 1'b1; in_valid4 = 1'b1;
            refModel(a, b, borrowIn, ed, eb, eo);
            @(posedge clk); #1;
            in_valid = 1'b0; in_valid4 = 1'b0;
            got1 = 1'b0; got4 = 1'b0; lat = 0; lat4 = 0;
            d = '0; bo = 1'b0; ov = 1'b0; d4 = '0; bo4 = 1'b0; ov4 = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (!got1 && out_valid) begin
                    got1 = 1'b1; lat = c; d = diff; bo = borrowOut; ov = overflow;
                end
                if (!got4 && out_valid4) begin
                    got4 = 1'b1; lat4 = c; d4 = diff4; bo4 = borrowOut4; ov4 = overflow4;
                end
                if (got1 && got4) break;
            end
            chk("rnd1_diff", 32'(d), 32'(ed));
            chk("rnd1_borrow", 32'(bo), 32'(eb));
            chk("rnd1_overflow", 32'(ov), 32'(eo));
            chk("rnd1_latency", 32'(lat), 32'd16);
            chk("rnd4_diff", 32'(d4), 32'(ed));
            chk("rnd4_borrow", 32'(bo4), 32'(eb));
            chk("rnd4_overflow", 32'(ov4), 32'(eo));
            chk("rnd4_latency", 32'(lat4), 32'd4);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
